led_blink_scheduler: RTL and testbench

- Command-driven controller that sequences one LED output through off, solid, finite-burst blink and continuous blink patterns.
- Replaces free-running derived-clock blinkers: all timing comes from a single-cycle tick enable on the system clock; no generated clocks.
- Sits between board-level control logic (buttons, FSMs) and the LED pin; other blocks issue commands through a valid/ready handshake.

---
 rtl/led_blink_scheduler_pkg.sv | 39 +++
 rtl/led_blink_scheduler_tick_gen.sv | 36 +++
 rtl/led_blink_scheduler.sv | 160 ++++++++++++++++
 tb/tb_led_blink_scheduler.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/led_blink_scheduler_pkg.sv
// led_blink_scheduler_pkg
// Shared encodings and sizing helpers for the LED blink scheduler and its
// tick generator.
//   mode_e    : command mode encoding carried on cmd_mode
//   state_e   : scheduler state encoding
//   calc_div  : clock cycles per tick
//   cnt_width : bits needed for a counter that runs 0..n-1 (at least 1)
//   max_int   : larger of two integers
package led_blink_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_SOLID = 2'd1,
    MODE_SLOW  = 2'd2,
    MODE_FAST  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SOLID = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } state_e;

  localparam int BLINK_W = 4;

  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_blink_scheduler_tick_gen.sv
// tick_gen
// Free-running divider that produces a one-cycle tick enable every DIV clocks.
//   clk   : system clock (rising edge)
//   reset : synchronous, active-low
//   clear : restart the count from 0 (takes priority over wrap)
//   tick  : high for one clock while the counter sits at DIV-1
// DIV must be at least 2 so that tick is low straight out of reset.
module tick_gen
  import led_blink_scheduler_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/led_blink_scheduler.sv
// led_blink_scheduler
// Command-driven LED sequencer: off, solid, finite-burst blink and continuous
// blink, all timed from a single tick enable on clk.
//   clk        : system clock
//   reset      : synchronous, active-low
//   cmd_valid  : command present
//   cmd_mode   : 0 OFF, 1 SOLID, 2 BLINK_SLOW, 3 BLINK_FAST
//   cmd_count  : number of blinks for modes 2/3, 0 = continuous
//   cmd_ready  : command accepted this cycle when cmd_valid is high
//   busy       : scheduler not idle
//   done       : one-cycle pulse when a finite burst finishes
//   light_out  : registered LED drive
//   tick_out   : tick enable, for observation
module led_blink_scheduler
  import led_blink_scheduler_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int SLOW_HALF = 50,
  parameter int FAST_HALF = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_mode,
  input  logic [3:0] cmd_count,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       light_out,
  output logic       tick_out
);

  localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
  localparam int PW  = cnt_width(max_int(SLOW_HALF, FAST_HALF));

  // Half-periods are stored as HALF-1 so the phase counter compares directly.
  localparam logic [PW-1:0] SLOW_M1 = PW'(SLOW_HALF - 1);
  localparam logic [PW-1:0] FAST_M1 = PW'(FAST_HALF - 1);

  state_e               state_reg, state_next;
  logic                 light_reg, light_next;
  logic                 done_reg, done_next;
  logic [PW-1:0]        half_m1_reg, half_m1_next;
  logic [PW-1:0]        phase_reg, phase_next;
  logic [BLINK_W-1:0]   count_reg, count_next;
  logic [BLINK_W-1:0]   blink_reg, blink_next;
  logic [BLINK_W-1:0]   blink_inc;
  logic                 tick;
  logic                 accept;
  logic                 phase_end;

  // Finite bursts lock out new commands; continuous blinking does not.
  assign cmd_ready = (state_reg == ST_IDLE) || (state_reg == ST_SOLID) ||
                     (count_reg == '0);
  assign accept    = cmd_valid && cmd_ready;
  assign phase_end = tick && (phase_reg == half_m1_reg);
  assign blink_inc = blink_reg + 1'b1;

  tick_gen #(
    .DIV(DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_IDLE;
      light_reg   <= 1'b0;
      done_reg    <= 1'b0;
      half_m1_reg <= '0;
      phase_reg   <= '0;
      count_reg   <= '0;
      blink_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      light_reg   <= light_next;
      done_reg    <= done_next;
      half_m1_reg <= half_m1_next;
      phase_reg   <= phase_next;
      count_reg   <= count_next;
      blink_reg   <= blink_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    light_next   = light_reg;
    done_next    = 1'b0;
    half_m1_next = half_m1_reg;
    phase_next   = phase_reg;
    count_next   = count_reg;
    blink_next   = blink_reg;

    if (accept) begin
      // A new command overrides any phase transition due this cycle.
      phase_next = '0;
      blink_next = '0;
      count_next = '0;
      case (mode_e'(cmd_mode))
        MODE_OFF: begin
          state_next = ST_IDLE;
          light_next = 1'b0;
        end
        MODE_SOLID: begin
          state_next = ST_SOLID;
          light_next = 1'b1;
        end
        default: begin
          state_next   = ST_ON;
          light_next   = 1'b1;
          count_next   = cmd_count;
          half_m1_next = (mode_e'(cmd_mode) == MODE_SLOW) ? SLOW_M1 : FAST_M1;
        end
      endcase
    end else begin
      case (state_reg)
        ST_ON: begin
          if (phase_end) begin
            state_next = ST_OFF;
            light_next = 1'b0;
            phase_next = '0;
          end else if (tick) begin
            phase_next = phase_reg + 1'b1;
          end
        end
        ST_OFF: begin
          if (phase_end) begin
            phase_next = '0;
            state_next = ST_ON;
            light_next = 1'b1;
            // Continuous mode leaves the blink counter untouched.
            if (count_reg != '0) begin
              blink_next = blink_inc;
              if (blink_inc == count_reg) begin
                state_next = ST_IDLE;
                light_next = 1'b0;
                done_next  = 1'b1;
                count_next = '0;
              end
            end
          end else if (tick) begin
            phase_next = phase_reg + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign light_out = light_reg;
  assign tick_out  = tick;

endmodule

// File: tb/tb_led_blink_scheduler.sv
module tb_led_blink_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic [3:0] cmd_count;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       light_out;
  logic       tick_out;

  int check_cnt = 0;
  int pass_cnt  = 0;

  led_blink_scheduler #(
    .CLK_HZ   (8),
    .TICK_HZ  (2),
    .SLOW_HALF(3),
    .FAST_HALF(1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_mode (cmd_mode),
    .cmd_count(cmd_count),
    .cmd_ready(cmd_ready),
    .busy     (busy),
    .done     (done),
    .light_out(light_out),
    .tick_out (tick_out)
  );

  always #5 clk = ~clk;

  // Advance one clock; everything (drive and sample) happens 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one edge.
  task automatic send(input logic [1:0] mode, input logic [3:0] count);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_count = count;
    cyc();
    cmd_valid = 1'b0;
    $display("t=%0t cmd mode=%0d count=%0d light=%0b busy=%0b ready=%0b",
             $time, mode, count, light_out, busy, cmd_ready);
  endtask

  initial begin
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_count = 4'd0;
    cyc();
    cyc();

    // 1. Reset state and idle tick cadence.
    check("rst_light", light_out, 0);
    check("rst_busy",  busy, 0);
    check("rst_done",  done, 0);
    check("rst_tick",  tick_out, 0);
    check("rst_ready", cmd_ready, 1);
    reset = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      check("idle_tick",  tick_out, (k % 4 == 3) ? 1 : 0);
      check("idle_light", light_out, 0);
      check("idle_busy",  busy, 0);
    end

    // 2. Slow burst of 2: 12 high / 12 low / 12 high / 12 low, done at 48.
    send(2'd2, 4'd2);
    check("b2_light0", light_out, 1);
    check("b2_ready0", cmd_ready, 0);
    for (int i = 1; i <= 48; i++) begin
      cyc();
      check("b2_light", light_out, (i < 48 && (i / 12) % 2 == 0) ? 1 : 0);
      check("b2_done",  done, (i == 48) ? 1 : 0);
      check("b2_ready", cmd_ready, (i == 48) ? 1 : 0);
      check("b2_busy",  busy, (i < 48) ? 1 : 0);
    end
    cyc();
    check("b2_done_end", done, 0);

    // 3. Fast continuous blink, then OFF mid-ON.
    send(2'd3, 4'd0);
    check("fc_light0", light_out, 1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("fc_light", light_out, ((i / 4) % 2 == 0) ? 1 : 0);
      check("fc_ready", cmd_ready, 1);
    end
    send(2'd0, 4'd0);
    check("off_light", light_out, 0);
    check("off_busy",  busy, 0);
    check("off_done",  done, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check("off_hold_light", light_out, 0);
      check("off_hold_done",  done, 0);
    end

    // 4. Solid for 100 cycles, then a single slow blink.
    send(2'd1, 4'd0);
    check("solid_busy",  busy, 1);
    check("solid_ready", cmd_ready, 1);
    for (int i = 1; i <= 100; i++) begin
      cyc();
      check("solid_light", light_out, 1);
    end
    send(2'd2, 4'd1);
    check("b1_light0", light_out, 1);
    for (int i = 1; i <= 24; i++) begin
      cyc();
      check("b1_light", light_out, (i < 12) ? 1 : 0);
      check("b1_done",  done, (i == 24) ? 1 : 0);
    end

    // 5. Reset mid-burst, then immediate new command.
    send(2'd2, 4'd3);
    for (int i = 1; i <= 26; i++) begin
      cyc();
    end
    check("b3_light_pre", light_out, 1);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    check("mid_rst_light", light_out, 0);
    check("mid_rst_busy",  busy, 0);
    check("mid_rst_done",  done, 0);
    check("mid_rst_tick",  tick_out, 0);
    check("mid_rst_ready", cmd_ready, 1);
    send(2'd1, 4'd0);
    check("post_rst_light", light_out, 1);
    check("post_rst_busy",  busy, 1);
    check("post_rst_done",  done, 0);
    send(2'd0, 4'd0);
    check("post_rst_off", light_out, 0);

    // 6. Command held during a fast burst of 1; accepted only once done.
    send(2'd3, 4'd1);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd1;
    cmd_count = 4'd0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      check("hold_light", light_out, (i < 4) ? 1 : 0);
      check("hold_ready", cmd_ready, (i == 8) ? 1 : 0);
      check("hold_done",  done, (i == 8) ? 1 : 0);
      check("hold_busy",  busy, (i < 8) ? 1 : 0);
    end
    cyc();
    cmd_valid = 1'b0;
    $display("t=%0t held cmd mode=1 light=%0b busy=%0b", $time, light_out, busy);
    check("held_acc_light", light_out, 1);
    check("held_acc_busy",  busy, 1);
    check("held_acc_done",  done, 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
